// File: rtl/core_pkg.sv
// Shared core types and sizes for the rename register file.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

  // Per-register architectural value plus its rename state.
  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } rename_entry_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational source-operand read port with same-cycle commit bypass.
module rf_read_port
  import core_pkg::*;
#(
  parameter int unsigned NUM_CM_PORTS = 2
) (
  input  logic [REG_IDX_W-1:0]              rs_in,
  input  rename_entry_t                     entry_in,
  input  logic [NUM_CM_PORTS-1:0]           cm_en_in,
  input  logic [NUM_CM_PORTS*REG_IDX_W-1:0] cm_rd_in,
  input  logic [NUM_CM_PORTS*TAG_W-1:0]     cm_tag_in,
  input  logic [NUM_CM_PORTS*XLEN-1:0]      cm_val_in,
  output logic                              busy_out,
  output logic [TAG_W-1:0]                  tag_out,
  output logic [XLEN-1:0]                   val_out
);

  logic            cm_hit;
  logic            cm_match;
  logic [XLEN-1:0] cm_val;

  // Youngest commit to rs decides the bypass, then fall back to stored state.
  always_comb begin
    cm_hit   = 1'b0;
    cm_match = 1'b0;
    cm_val   = '0;
    busy_out = 1'b0;
    tag_out  = '0;
    val_out  = '0;
    for (int unsigned p = 0; p < NUM_CM_PORTS; p++) begin
      if (cm_en_in[p] && (cm_rd_in[p*REG_IDX_W +: REG_IDX_W] == rs_in)) begin
        cm_hit   = 1'b1;
        cm_match = (cm_tag_in[p*TAG_W +: TAG_W] == entry_in.tag);
        cm_val   = cm_val_in[p*XLEN +: XLEN];
      end
    end
    if (rs_in != '0) begin
      if (cm_hit && (cm_match || !entry_in.busy)) begin
        val_out = cm_val;
      end else if (entry_in.busy) begin
        busy_out = 1'b1;
        tag_out  = entry_in.tag;
      end else begin
        val_out = entry_in.val;
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with busy/tag rename state, ROB commit and flush.
module rename_reg_file
  import core_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_CM_PORTS = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              rdy_in,
  input  logic                              disp_en_in,
  input  logic [REG_IDX_W-1:0]              disp_rd_in,
  input  logic [TAG_W-1:0]                  disp_tag_in,
  input  logic [NUM_RD_PORTS*REG_IDX_W-1:0] rs_in,
  output logic [NUM_RD_PORTS-1:0]           rs_busy_out,
  output logic [NUM_RD_PORTS*TAG_W-1:0]     rs_tag_out,
  output logic [NUM_RD_PORTS*XLEN-1:0]      rs_val_out,
  input  logic [NUM_CM_PORTS-1:0]           cm_en_in,
  input  logic [NUM_CM_PORTS*REG_IDX_W-1:0] cm_rd_in,
  input  logic [NUM_CM_PORTS*TAG_W-1:0]     cm_tag_in,
  input  logic [NUM_CM_PORTS*XLEN-1:0]      cm_val_in,
  input  logic                              flush_in
);

  rename_entry_t                 regs_q [NUM_REGS];
  rename_entry_t                 regs_d [NUM_REGS];
  logic                          cm_hit;
  logic                          cm_match;
  logic [NUM_CM_PORTS-1:0]       cm_rd_en;

  // Next state: commits write values, then flush or dispatch rewrite rename state.
  always_comb begin
    regs_d   = regs_q;
    cm_hit   = 1'b0;
    cm_match = 1'b0;
    if (rdy_in) begin
      // x0 is skipped so it stays at its reset value forever.
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        cm_hit   = 1'b0;
        cm_match = 1'b0;
        for (int unsigned p = 0; p < NUM_CM_PORTS; p++) begin
          if (cm_en_in[p] && (cm_rd_in[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))) begin
            cm_hit        = 1'b1;
            cm_match      = (cm_tag_in[p*TAG_W +: TAG_W] == regs_q[r].tag);
            regs_d[r].val = cm_val_in[p*XLEN +: XLEN];
          end
        end
        // Clearing an already-idle entry is harmless, so busy need not be tested.
        if (cm_hit && cm_match) begin
          regs_d[r].busy = 1'b0;
        end
        if (flush_in) begin
          regs_d[r].busy = 1'b0;
          regs_d[r].tag  = '0;
        end else if (disp_en_in && (disp_rd_in == REG_IDX_W'(r))) begin
          regs_d[r].busy = 1'b1;
          regs_d[r].tag  = disp_tag_in;
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass only reflects commits that will actually land.
  assign cm_rd_en = (rdy_in && rst_n_in) ? cm_en_in : '0;

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic [REG_IDX_W-1:0] rs;
    assign rs = rs_in[i*REG_IDX_W +: REG_IDX_W];

    rf_read_port #(
      .NUM_CM_PORTS(NUM_CM_PORTS)
    ) u_rd (
      .rs_in    (rs),
      .entry_in (regs_q[rs]),
      .cm_en_in (cm_rd_en),
      .cm_rd_in (cm_rd_in),
      .cm_tag_in(cm_tag_in),
      .cm_val_in(cm_val_in),
      .busy_out (rs_busy_out[i]),
      .tag_out  (rs_tag_out[i*TAG_W +: TAG_W]),
      .val_out  (rs_val_out[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios plus randomized traffic.
module tb_rename_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        disp_en_in;
  logic [4:0]  disp_rd_in;
  logic [4:0]  disp_tag_in;
  logic        flush_in;
  logic [9:0]  rs_in;
  logic [1:0]  rs_busy_out;
  logic [9:0]  rs_tag_out;
  logic [63:0] rs_val_out;
  logic [1:0]  cm_en_in;
  logic [9:0]  cm_rd_in;
  logic [9:0]  cm_tag_in;
  logic [63:0] cm_val_in;

  logic [4:0]  b_rs     [2];
  logic        b_cm_en  [2];
  logic [4:0]  b_cm_rd  [2];
  logic [4:0]  b_cm_tag [2];
  logic [31:0] b_cm_val [2];
  logic [37:0] obs      [2];

  // Reference state: plain per-register arrays.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [4:0]  m_tag  [32];

  int total = 0;
  int bad   = 0;

  assign rs_in     = {b_rs[1], b_rs[0]};
  assign cm_en_in  = {b_cm_en[1], b_cm_en[0]};
  assign cm_rd_in  = {b_cm_rd[1], b_cm_rd[0]};
  assign cm_tag_in = {b_cm_tag[1], b_cm_tag[0]};
  assign cm_val_in = {b_cm_val[1], b_cm_val[0]};
  assign obs[0]    = {rs_busy_out[0], rs_tag_out[4:0], rs_val_out[31:0]};
  assign obs[1]    = {rs_busy_out[1], rs_tag_out[9:5], rs_val_out[63:32]};

  always #5 clk_in = ~clk_in;

  rename_reg_file #(
    .NUM_RD_PORTS(2),
    .NUM_CM_PORTS(2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .disp_en_in (disp_en_in),
    .disp_rd_in (disp_rd_in),
    .disp_tag_in(disp_tag_in),
    .rs_in      (rs_in),
    .rs_busy_out(rs_busy_out),
    .rs_tag_out (rs_tag_out),
    .rs_val_out (rs_val_out),
    .cm_en_in   (cm_en_in),
    .cm_rd_in   (cm_rd_in),
    .cm_tag_in  (cm_tag_in),
    .cm_val_in  (cm_val_in),
    .flush_in   (flush_in)
  );

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
  endtask

  // Expected {busy, tag, val} seen by a read of r under the current inputs.
  function automatic logic [37:0] exp_read(input logic [4:0] r);
    logic        hit = 1'b0;
    logic [4:0]  t = '0;
    logic [31:0] v = '0;
    if (r == 5'd0) return '0;
    if (rdy_in && rst_n_in) begin
      for (int p = 0; p < 2; p++) begin
        if (b_cm_en[p] && b_cm_rd[p] == r) begin
          hit = 1'b1; t = b_cm_tag[p]; v = b_cm_val[p];
        end
      end
    end
    if (hit && (!m_busy[r] || m_tag[r] == t)) return {1'b0, 5'd0, v};
    if (m_busy[r]) return {1'b1, m_tag[r], 32'd0};
    return {1'b0, 5'd0, m_val[r]};
  endfunction

  // Apply one clock of architectural effect to the reference.
  task automatic model_step();
    logic        nbusy [32];
    int          last;
    if (!rdy_in) return;
    for (int r = 0; r < 32; r++) nbusy[r] = m_busy[r];
    for (int r = 1; r < 32; r++) begin
      last = -1;
      for (int p = 0; p < 2; p++) if (b_cm_en[p] && b_cm_rd[p] == 5'(r)) last = p;
      if (last >= 0) begin
        m_val[r] = b_cm_val[last];
        if (m_busy[r] && m_tag[r] == b_cm_tag[last]) nbusy[r] = 1'b0;
      end
    end
    for (int r = 0; r < 32; r++) m_busy[r] = nbusy[r];
    if (flush_in) begin
      for (int r = 0; r < 32; r++) begin
        m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else if (disp_en_in && disp_rd_in != 5'd0) begin
      m_busy[disp_rd_in] = 1'b1;
      m_tag[disp_rd_in]  = disp_tag_in;
    end
  endtask

  task automatic set_idle();
    rdy_in = 1'b1; disp_en_in = 1'b0; disp_rd_in = '0; disp_tag_in = '0; flush_in = 1'b0;
    for (int p = 0; p < 2; p++) begin
      b_rs[p] = '0; b_cm_en[p] = 1'b0; b_cm_rd[p] = '0; b_cm_tag[p] = '0; b_cm_val[p] = '0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic commit(input int p, input logic [4:0] rd, input logic [4:0] tag,
                        input logic [31:0] val);
    b_cm_en[p] = 1'b1; b_cm_rd[p] = rd; b_cm_tag[p] = tag; b_cm_val[p] = val;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [4:0] tag);
    disp_en_in = 1'b1; disp_rd_in = rd; disp_tag_in = tag;
  endtask

  task automatic test_reset();
    logic [37:0] exp;
    set_idle(); dispatch(5'd5, 5'd1); tick();
    set_idle();
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    b_rs[0] = 5'd5; b_rs[1] = 5'd5; commit(0, 5'd5, 5'd1, 32'h1234);
    #1;
    exp = '0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== exp) begin
        bad++; $display("FAIL reset_async port%0d got=%h want=%h", i, obs[i], exp);
      end
    end
    model_clear();
    set_idle();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int r = 0; r < 32; r++) begin
      b_rs[0] = 5'(r); b_rs[1] = 5'(31 - r);
      #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp) begin
          bad++; $display("FAIL reset_scan rs=%0d got=%h want=%h", b_rs[i], obs[i], exp);
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_dispatch_commit();
    logic [37:0] exp;
    set_idle(); dispatch(5'd5, 5'd3); b_rs[0] = 5'd5;
    #1;
    exp = '0; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL dc_old_map got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); b_rs[0] = 5'd5;
    #1;
    exp = {1'b1, 5'd3, 32'd0}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL dc_busy got=%h want=%h", obs[0], exp); end
    commit(0, 5'd5, 5'd3, 32'hDEADBEEF);
    #1;
    exp = {1'b0, 5'd0, 32'hDEADBEEF}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL dc_bypass got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); b_rs[0] = 5'd5;
    #1;
    total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL dc_done got=%h want=%h", obs[0], exp); end
  endtask

  task automatic test_stale_commit();
    logic [37:0] exp;
    set_idle(); dispatch(5'd7, 5'd2); tick();
    set_idle(); dispatch(5'd7, 5'd9); tick();
    set_idle(); commit(0, 5'd7, 5'd2, 32'h11); b_rs[0] = 5'd7;
    #1;
    exp = {1'b1, 5'd9, 32'd0}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL stale_bypass got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); b_rs[0] = 5'd7;
    #1;
    total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL stale_busy got=%h want=%h", obs[0], exp); end
    flush_in = 1'b1; tick();
    set_idle(); b_rs[0] = 5'd7;
    #1;
    exp = {1'b0, 5'd0, 32'h11}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL stale_val got=%h want=%h", obs[0], exp); end
  endtask

  task automatic test_same_cycle();
    logic [37:0] exp;
    set_idle(); dispatch(5'd4, 5'd6); tick();
    set_idle(); commit(1, 5'd4, 5'd6, 32'hCAFE0004); dispatch(5'd4, 5'd8); b_rs[0] = 5'd4;
    #1;
    exp = {1'b0, 5'd0, 32'hCAFE0004}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL same_bypass got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); b_rs[0] = 5'd4;
    #1;
    exp = {1'b1, 5'd8, 32'd0}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL same_rename got=%h want=%h", obs[0], exp); end
    flush_in = 1'b1; tick();
    set_idle(); b_rs[0] = 5'd4;
    #1;
    exp = {1'b0, 5'd0, 32'hCAFE0004}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL same_val got=%h want=%h", obs[0], exp); end
  endtask

  task automatic test_dual_commit();
    logic [37:0] exp;
    set_idle(); dispatch(5'd9, 5'd10); tick();
    set_idle(); commit(0, 5'd9, 5'd10, 32'd1); commit(1, 5'd9, 5'd10, 32'd2); b_rs[0] = 5'd9;
    #1;
    exp = {1'b0, 5'd0, 32'd2}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL dual_bypass got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); commit(0, 5'd0, 5'd0, 32'h55); dispatch(5'd0, 5'd4);
    b_rs[0] = 5'd0; b_rs[1] = 5'd9;
    #1;
    total++;
    if (obs[1] !== exp) begin bad++; $display("FAIL dual_val got=%h want=%h", obs[1], exp); end
    total++;
    if (obs[0] !== 38'd0) begin bad++; $display("FAIL x0_bypass got=%h want=0", obs[0]); end
    tick();
    set_idle(); b_rs[0] = 5'd0;
    #1;
    total++;
    if (obs[0] !== 38'd0) begin bad++; $display("FAIL x0_write got=%h want=0", obs[0]); end
  endtask

  task automatic test_flush();
    logic [37:0] exp;
    set_idle(); dispatch(5'd6, 5'd12); tick();
    set_idle(); dispatch(5'd2, 5'd13); tick();
    set_idle(); flush_in = 1'b1; dispatch(5'd3, 5'd14); commit(0, 5'd6, 5'd12, 32'h77);
    b_rs[0] = 5'd6;
    #1;
    exp = {1'b0, 5'd0, 32'h77}; total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL flush_bypass got=%h want=%h", obs[0], exp); end
    tick();
    set_idle(); b_rs[0] = 5'd6; b_rs[1] = 5'd3;
    #1;
    total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL flush_val got=%h want=%h", obs[0], exp); end
    total++;
    if (obs[1] !== 38'd0) begin bad++; $display("FAIL flush_drop got=%h want=0", obs[1]); end
    b_rs[1] = 5'd2;
    #1;
    total++;
    if (obs[1] !== 38'd0) begin bad++; $display("FAIL flush_busy got=%h want=0", obs[1]); end
  endtask

  task automatic test_hold();
    logic [37:0] exp;
    set_idle(); dispatch(5'd8, 5'd1); tick();
    exp = {1'b1, 5'd1, 32'd0};
    for (int c = 0; c < 3; c++) begin
      set_idle(); rdy_in = 1'b0; dispatch(5'd8, 5'd2); commit(0, 5'd8, 5'd1, 32'h99);
      flush_in = 1'b1; b_rs[0] = 5'd8;
      #1;
      total++;
      if (obs[0] !== exp) begin bad++; $display("FAIL hold_c%0d got=%h want=%h", c, obs[0], exp); end
      tick();
    end
    set_idle(); b_rs[0] = 5'd8;
    #1;
    total++;
    if (obs[0] !== exp) begin bad++; $display("FAIL hold_after got=%h want=%h", obs[0], exp); end
  endtask

  task automatic test_random();
    logic [37:0] exp;
    logic [4:0]  r;
    for (int c = 0; c < 400; c++) begin
      set_idle();
      rdy_in   = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) dispatch(5'($urandom_range(0, 7)), 5'($urandom));
      for (int p = 0; p < 2; p++) begin
        r = 5'($urandom_range(0, 7));
        b_cm_en[p]  = ($urandom_range(0, 2) != 0);
        b_cm_rd[p]  = r;
        b_cm_tag[p] = ($urandom_range(0, 2) != 0) ? m_tag[r] : 5'($urandom);
        b_cm_val[p] = $urandom;
        b_rs[p]     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        exp = exp_read(b_rs[i]); total++;
        if (obs[i] !== exp) begin
          bad++;
          $display("FAIL rand c=%0d port%0d rs=%0d got=%h want=%h", c, i, b_rs[i], obs[i], exp);
        end
      end
      tick();
    end
    set_idle();
    for (int q = 0; q < 32; q++) begin
      b_rs[0] = 5'(q);
      #1;
      exp = exp_read(b_rs[0]); total++;
      if (obs[0] !== exp) begin
        bad++; $display("FAIL rand_scan rs=%0d got=%h want=%h", q, obs[0], exp);
      end
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    set_idle();
    model_clear();
    #12;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    test_reset();
    test_dispatch_commit();
    test_stale_commit();
    test_same_cycle();
    test_dual_commit();
    test_flush();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
